// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: requester handshakes, register-file write port and arbiter counters
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
);
  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NREG-1:0]   wr_en;
  logic [7:0]        conflict_cnt;
  logic [7:0]        drop_cnt;
  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, wr_valid, wr_addr, wr_data, wr_en, conflict_cnt, drop_cnt
  );
  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, wr_valid, wr_addr, wr_data, wr_en, conflict_cnt, drop_cnt
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin sharing of the register-file write port with one-hot enable
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input logic                  clk,
  input logic                  reset,
  regfile_write_arbiter_if.slave bus
);
  typedef enum logic {LAST_A, LAST_B} last_t;
  last_t             last_q, last_d;
  logic              grant_a, grant_b, xfer, hit;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              wr_valid_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [NREG-1:0]   wr_en_q;
  logic [7:0]        conflict_q, drop_q;
  always_comb begin
    grant_a  = !reset && bus.a_valid && (!bus.b_valid || last_q == LAST_B);
    grant_b  = !reset && bus.b_valid && (!bus.a_valid || last_q == LAST_A);
    xfer     = grant_a || grant_b;
    sel_addr = grant_a ? bus.a_addr : bus.b_addr;
    sel_data = grant_a ? bus.a_data : bus.b_data;
    hit      = xfer && sel_addr != '0;
    last_d   = grant_a ? LAST_A : grant_b ? LAST_B : last_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q     <= LAST_B;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= '0;
      conflict_q <= '0;
      drop_q     <= '0;
    end else begin
      last_q     <= last_d;
      wr_valid_q <= hit;
      wr_en_q    <= hit ? NREG'(1) << sel_addr : '0;
      if (xfer) begin
        wr_addr_q <= sel_addr;
        wr_data_q <= sel_data;
      end
      if (bus.a_valid && bus.b_valid && conflict_q != 8'hFF) conflict_q <= conflict_q + 8'd1;
      // writes to r0 are accepted but never reach the array
      if (xfer && !hit && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
  end
  assign bus.a_ready      = grant_a;
  assign bus.b_ready      = grant_b;
  assign bus.wr_valid     = wr_valid_q;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.wr_en        = wr_en_q;
  assign bus.conflict_cnt = conflict_q;
  assign bus.drop_cnt     = drop_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed and randomized checks against a behavioural write-port model
module tb_regfile_write_arbiter;
  logic clk = 1'b0;
  logic reset;
  int n_cmp = 0;
  int n_err = 0;
  bit m_last_b;
  bit m_valid;
  logic [4:0] m_addr;
  logic [31:0] m_data;
  int m_conf, m_drop;
  logic [31:0] ref_rf [32];
  logic [31:0] dut_rf [32];
  regfile_write_arbiter_if #(.DATA_W(32), .ADDR_W(5), .NREG(32)) bus ();
  regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .NREG(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input bit rs, input bit av, input logic [4:0] aa, input logic [31:0] ad,
                     input bit bv, input logic [4:0] ba, input logic [31:0] bd,
                     output bit ga, output bit gb);
    reset = rs;
    bus.a_valid = av; bus.a_addr = aa; bus.a_data = ad;
    bus.b_valid = bv; bus.b_addr = ba; bus.b_data = bd;
    #1;
    ga = !rs && av && (!bv || m_last_b);
    gb = !rs && bv && (!av || !m_last_b);
    chk("a_ready", 32'(bus.a_ready), 32'(ga));
    chk("b_ready", 32'(bus.b_ready), 32'(gb));
    @(posedge clk);
    #1;
    if (rs) begin
      m_valid = 0; m_addr = 0; m_data = 0; m_conf = 0; m_drop = 0; m_last_b = 1;
    end else begin
      if (ga || gb) begin
        m_addr  = ga ? aa : ba;
        m_data  = ga ? ad : bd;
        m_valid = m_addr != 0;
        if (m_valid) ref_rf[m_addr] = m_data;
        else if (m_drop < 255) m_drop++;
        m_last_b = gb;
      end else m_valid = 0;
      if (av && bv && m_conf < 255) m_conf++;
    end
    chk("wr_valid", 32'(bus.wr_valid), 32'(m_valid));
    chk("wr_addr", 32'(bus.wr_addr), 32'(m_addr));
    chk("wr_data", bus.wr_data, m_data);
    chk("wr_en", bus.wr_en, m_valid ? 32'h1 << m_addr : 32'h0);
    chk("conflict_cnt", 32'(bus.conflict_cnt), 32'(m_conf));
    chk("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
    if (bus.wr_valid) dut_rf[bus.wr_addr] = bus.wr_data;
  endtask
  initial begin
    bit ga, gb, pa, pb, rs;
    logic [4:0] paa, pba;
    logic [31:0] pad, pbd;
    for (int i = 0; i < 32; i++) begin ref_rf[i] = 0; dut_rf[i] = 0; end
    m_last_b = 1; m_valid = 0; m_addr = 0; m_data = 0; m_conf = 0; m_drop = 0;
    cyc(1, 0, 0, 0, 0, 0, 0, ga, gb);
    cyc(1, 0, 0, 0, 0, 0, 0, ga, gb);
    chk("reset_wr_en", bus.wr_en, 32'h0);
    cyc(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, ga, gb);
    chk("single_wr_en", bus.wr_en, 32'h20);
    chk("single_wr_data", bus.wr_data, 32'hDEADBEEF);
    cyc(0, 0, 0, 0, 0, 0, 0, ga, gb);
    chk("single_after_wr_en", bus.wr_en, 32'h0);
    cyc(1, 0, 0, 0, 0, 0, 0, ga, gb);
    cyc(0, 1, 3, 32'h33, 1, 7, 32'h77, ga, gb);
    chk("tie_first_a", 32'(ga), 32'd1);
    chk("tie_wr_en_a", bus.wr_en, 32'h8);
    cyc(0, 0, 0, 0, 1, 7, 32'h77, ga, gb);
    chk("tie_wr_en_b", bus.wr_en, 32'h80);
    chk("tie_conflict", 32'(bus.conflict_cnt), 32'd1);
    cyc(1, 0, 0, 0, 0, 0, 0, ga, gb);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, 5'(1 + i), 32'hA000 + i, 1, 5'(10 + i), 32'hB000 + i, ga, gb);
      chk("alt_grant_a", 32'(ga), 32'(i % 2 == 0));
      chk("alt_no_bubble", 32'(bus.wr_valid), 32'd1);
    end
    chk("alt_conflict", 32'(bus.conflict_cnt), 32'd6);
    cyc(1, 0, 0, 0, 0, 0, 0, ga, gb);
    cyc(0, 1, 0, 32'h1234, 0, 0, 0, ga, gb);
    chk("r0_drop", 32'(bus.drop_cnt), 32'd1);
    chk("r0_wr_en", bus.wr_en, 32'h0);
    cyc(0, 1, 31, 32'h31313131, 0, 0, 0, ga, gb);
    chk("r31_wr_en", bus.wr_en, 32'h80000000);
    for (int i = 0; i < 300; i++)
      cyc(0, 1, 5'($urandom_range(1, 31)), $urandom, 1, 5'($urandom_range(1, 31)), $urandom, ga, gb);
    chk("conflict_sat", 32'(bus.conflict_cnt), 32'd255);
    cyc(0, 1, 4, 32'h4, 1, 6, 32'h6, ga, gb);
    chk("conflict_hold", 32'(bus.conflict_cnt), 32'd255);
    cyc(0, 1, 9, 32'h99, 0, 0, 0, ga, gb);
    chk("r9_wr_en", bus.wr_en, 32'h200);
    cyc(1, 1, 12, 32'hC, 1, 13, 32'hD, ga, gb);
    chk("rst_wr_valid", 32'(bus.wr_valid), 32'd0);
    chk("rst_conflict", 32'(bus.conflict_cnt), 32'd0);
    cyc(0, 1, 12, 32'hC, 1, 13, 32'hD, ga, gb);
    chk("rst_tie_a", 32'(ga), 32'd1);
    pa = 0; pb = 0; paa = 0; pba = 0; pad = 0; pbd = 0;
    for (int i = 0; i < 600; i++) begin
      if (!pa && $urandom_range(0, 2) != 0) begin
        pa = 1; paa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom); pad = $urandom;
      end
      if (!pb && $urandom_range(0, 2) != 0) begin
        pb = 1; pba = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom); pbd = $urandom;
      end
      rs = $urandom_range(0, 59) == 0;
      cyc(rs, pa, paa, pad, pb, pba, pbd, ga, gb);
      if (ga) pa = 0;
      if (gb) pb = 0;
    end
    for (int i = 1; i < 32; i++) chk($sformatf("rf[%0d]", i), dut_rf[i], ref_rf[i]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
